// File: rtl/spi_master_ctrl.sv
// Byte-wide SPI master: one 8-bit write or read frame per start request, sck idle low.
// Optional macro SPI_MASTER_LSB_FIRST_EN selects LSB-first bit order on mosi and miso.
module spi_master_ctrl #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rd,
    input  logic [7:0] txdata,
    output logic [7:0] rxdata,
    output logic       busy,
    output logic       done,
    output logic       sck,
    output logic       cs,
    output logic       rw,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned BW = 3;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [BW-1:0]  bit_cnt, bit_cnt_n;
    logic [DW-1:0]  tx_sr, tx_n;
    logic [DW-1:0]  rx_sr, rx_n;
    logic           rd_q, rd_n;
    logic           sck_n, cs_n, rw_n, mosi_n, busy_n, done_n;
    logic [DW-1:0]  rxdata_n;
    logic           phase_end;

    // tx register holds the bits still to be sent; mosi already carries the current one
    logic [DW-1:0]  tx_load, tx_shift, rx_shift;
    logic           tx_head, tx_next;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_head  = txdata[0];
    assign tx_load  = {1'b0, txdata[DW-1:1]};
    assign tx_next  = tx_sr[0];
    assign tx_shift = {1'b0, tx_sr[DW-1:1]};
    assign rx_shift = {miso, rx_sr[DW-1:1]};
`else
    assign tx_head  = txdata[DW-1];
    assign tx_load  = {txdata[DW-2:0], 1'b0};
    assign tx_next  = tx_sr[DW-1];
    assign tx_shift = {tx_sr[DW-2:0], 1'b0};
    assign rx_shift = {rx_sr[DW-2:0], miso};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        tx_n      = tx_sr;
        rx_n      = rx_sr;
        rd_n      = rd_q;
        sck_n     = sck;
        cs_n      = cs;
        rw_n      = rw;
        mosi_n    = mosi;
        busy_n    = busy;
        done_n    = 1'b0;
        rxdata_n  = rxdata;
        phase_end = (cnt == CNT_LAST);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n   = S_SETUP;
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    rd_n      = rd;
                    tx_n      = tx_load;
                    busy_n    = 1'b1;
                    cs_n      = 1'b0;
                    rw_n      = rd;
                    mosi_n    = rd ? 1'b0 : tx_head;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    cnt_n   = '0;
                    state_n = S_SHIFT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_SHIFT: begin
                if (phase_end) begin
                    cnt_n = '0;
                    if (!sck) begin
                        sck_n = 1'b1;
                        if (rd_q) rx_n = rx_shift;
                    end else begin
                        sck_n     = 1'b0;
                        bit_cnt_n = bit_cnt + BW'(1);
                        if (bit_cnt == BW'(DW - 1)) begin
                            state_n = S_HOLD;
                        end else if (!rd_q) begin
                            mosi_n = tx_next;
                            tx_n   = tx_shift;
                        end
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_HOLD: begin
                if (phase_end) begin
                    cnt_n   = '0;
                    state_n = S_GAP;
                    cs_n    = 1'b1;
                    rw_n    = 1'b0;
                    mosi_n  = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (phase_end) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    if (rd_q) rxdata_n = rx_sr;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rd_q    <= 1'b0;
            sck     <= 1'b0;
            cs      <= 1'b1;
            rw      <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rxdata  <= '0;
        end else begin
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            tx_sr   <= tx_n;
            rx_sr   <= rx_n;
            rd_q    <= rd_n;
            sck     <= sck_n;
            cs      <= cs_n;
            rw      <= rw_n;
            mosi    <= mosi_n;
            busy    <= busy_n;
            done    <= done_n;
            rxdata  <= rxdata_n;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomized bench for spi_master_ctrl against a frame-level reference model and slave model.
module tb_spi_master_ctrl;

    localparam int unsigned D = 2;
`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] txdata = 8'h00;
    logic       miso = 1'b0;
    logic [7:0] rxdata;
    logic       busy, done, sck, cs, rw, mosi;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_rx = 8'h00;

    spi_master_ctrl #(.CLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd(rd), .txdata(txdata),
        .rxdata(rxdata), .busy(busy), .done(done), .sck(sck), .cs(cs),
        .rw(rw), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // i-th bit placed on the wire for byte b
    function automatic logic wire_bit(input logic [7:0] b, input int i);
        logic [2:0] idx;
        idx = 3'(i);
        return LSB_FIRST ? b[idx] : b[3'd7 - idx];
    endfunction

    // Runs one frame starting at the current negedge; returns in the done cycle.
    task automatic run_frame(input logic rd_i, input logic [7:0] tx_i, input logic [7:0] sb,
                             input int inject_at, input string nm);
        int cs_low, first_rise, done_at, rises, falls, last_chg, stab_viol, rw_bad;
        logic [7:0] seq, exp_seq, rx_at_done;
        logic prev_sck, prev_mosi, busy0, cs0, busy_done;
        start = 1'b1; rd = rd_i; txdata = tx_i;
        cs_low = 0; first_rise = -1; done_at = -1; rises = 0; falls = 0;
        last_chg = -1; stab_viol = 0; rw_bad = 0; seq = 8'h00; rx_at_done = 8'h00;
        prev_sck = 1'b0; prev_mosi = mosi; busy0 = 1'b0; cs0 = 1'b1; busy_done = 1'b1;
        @(posedge clk);
        for (int c = 0; c < int'(19 * D + 4) && done_at < 0; c++) begin
            @(negedge clk);
            start  = (c == inject_at);
            rd     = 1'($urandom);
            txdata = 8'($urandom);
            if (c == 0) begin busy0 = busy; cs0 = cs; end
            if (!cs) cs_low++;
            if ((!cs && rw !== rd_i) || (cs && rw !== 1'b0)) rw_bad++;
            if (mosi !== prev_mosi) last_chg = c;
            prev_mosi = mosi;
            if (sck && !prev_sck) begin
                rises++;
                if (first_rise < 0) first_rise = c;
                seq = {seq[6:0], mosi};
                if (c - last_chg < int'(D)) stab_viol++;
            end
            if (!sck && prev_sck) falls++;
            prev_sck = sck;
            if (done) begin done_at = c; rx_at_done = rxdata; busy_done = busy; end
            miso = (!cs && falls < 8) ? wire_bit(sb, falls) : 1'($urandom);
        end
        exp_seq = 8'h00;
        for (int i = 0; i < 8; i++) exp_seq = {exp_seq[6:0], rd_i ? 1'b0 : wire_bit(tx_i, i)};
        if (rd_i) model_rx = sb;
        check({nm, "_busy_start"}, 32'(busy0), 32'd1);
        check({nm, "_cs_fall"}, 32'(cs0), 32'd0);
        check({nm, "_done_at"}, 32'(done_at), 32'(19 * D));
        check({nm, "_cs_low"}, 32'(cs_low), 32'(18 * D));
        check({nm, "_first_rise"}, 32'(first_rise), 32'(2 * D));
        check({nm, "_rises"}, 32'(rises), 32'd8);
        check({nm, "_mosi_bits"}, 32'(seq), 32'(exp_seq));
        check({nm, "_mosi_setup"}, 32'(stab_viol), 32'd0);
        check({nm, "_rw"}, 32'(rw_bad), 32'd0);
        check({nm, "_busy_done"}, 32'(busy_done), 32'd0);
        check({nm, "_rxdata"}, 32'(rx_at_done), 32'(model_rx));
    endtask

    // Idle cycles: no frame may start and no done may appear
    task automatic idle(input int n, input string nm);
        int dones, lows;
        dones = 0; lows = 0;
        start = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (done) dones++;
            if (!cs) lows++;
            miso = 1'($urandom);
        end
        check({nm, "_no_done"}, 32'(dones), 32'd0);
        check({nm, "_no_cs"}, 32'(lows), 32'd0);
    endtask

    task automatic abort_test();
        int rises;
        logic prev_sck;
        rises = 0; prev_sck = 1'b0;
        start = 1'b1; rd = 1'b1; txdata = 8'hFF;
        for (int c = 0; c < 40 && rises < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (sck && !prev_sck) rises++;
            prev_sck = sck;
            miso = 1'b1;
        end
        check("abort_reach_rise3", 32'(rises), 32'd3);
        rst_n = 1'b0;
        #1;
        check("abort_cs", 32'(cs), 32'd1);
        check("abort_sck", 32'(sck), 32'd0);
        check("abort_rw", 32'(rw), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rxdata", 32'(rxdata), 32'd0);
        model_rx = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        idle(19 * D + 4, "abort_after");
    endtask

    initial begin
        int gap;
        logic r;
        logic [7:0] t, s;
        repeat (3) @(negedge clk);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_rw", 32'(rw), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rxdata", 32'(rxdata), 32'd0);
        rst_n = 1'b1;
        idle(2, "post_rst");

        run_frame(1'b1, 8'h00, 8'h3C, -1, "rd_3c");
        idle(2, "g1");
        run_frame(1'b0, 8'hA5, 8'hC3, -1, "wr_a5");
        idle(2, "g2");
        run_frame(1'b0, 8'h96, 8'h00, 9 * D, "mid_start");
        idle(19 * D + 4, "mid_ignored");
        run_frame(1'b1, 8'h00, 8'h81, -1, "b2b_a");
        run_frame(1'b0, 8'h42, 8'h00, -1, "b2b_b");
        idle(3, "g3");
        abort_test();
        run_frame(1'b0, 8'h5A, 8'hFF, -1, "wr_5a");
        idle(2, "g4");
        run_frame(1'b0, 8'h01, 8'h00, -1, "wr_01");
        idle(1, "g5");
        run_frame(1'b1, 8'h00, 8'h01, -1, "rd_01");

        for (int i = 0; i < 20; i++) begin
            gap = int'($urandom_range(0, 2));
            if (gap > 0) idle(gap, "rnd_gap");
            r = 1'($urandom);
            t = 8'($urandom);
            s = 8'($urandom);
            run_frame(r, t, s, -1, "rnd");
        end
        idle(4, "tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
